// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: memory op codes and access-size decode shared by the MEM-stage bus controller.
package mem_bus_ctrl_pkg;
   localparam logic [3:0] MEM_OP_NONE = 4'd0;
   localparam logic [3:0] MEM_OP_LB   = 4'd1;
   localparam logic [3:0] MEM_OP_LBU  = 4'd2;
   localparam logic [3:0] MEM_OP_LH   = 4'd3;
   localparam logic [3:0] MEM_OP_LHU  = 4'd4;
   localparam logic [3:0] MEM_OP_LW   = 4'd5;
   localparam logic [3:0] MEM_OP_SB   = 4'd6;
   localparam logic [3:0] MEM_OP_SH   = 4'd7;
   localparam logic [3:0] MEM_OP_SW   = 4'd8;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
   function automatic size_t op_size(input logic [3:0] op);
      return (op == MEM_OP_LB || op == MEM_OP_LBU || op == MEM_OP_SB) ? SZ_B :
             (op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_SH) ? SZ_H : SZ_W;
   endfunction
endpackage

// File: rtl/mem_bus_ctrl_align.sv
// mem_align: lane select/replication, misalignment detection and big-endian load extract/extend.
module mem_align
   import mem_bus_ctrl_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  off,
   input  logic [31:0] sdata,
   input  logic [31:0] rdata,
   output logic        valid,
   output logic        we,
   output logic        mis,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);
   size_t       sz;
   logic        sext;
   logic [31:0] rs;
   logic [15:0] h;
   always_comb begin
      valid = op >= MEM_OP_LB && op <= MEM_OP_SW;
      we    = op >= MEM_OP_SB && op <= MEM_OP_SW;
      sz    = op_size(op);
      sext  = op == MEM_OP_LB || op == MEM_OP_LH;
      mis   = valid && (sz == SZ_H ? off[0] : sz == SZ_W ? off != 2'd0 : 1'b0);
      sel   = sz == SZ_B ? 4'b1000 >> off : sz == SZ_H ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
      wdata = sz == SZ_B ? {4{sdata[7:0]}} : sz == SZ_H ? {2{sdata[15:0]}} : sdata;
      // byte offset 0 lives in the top lane, so shift right by (3 - off) bytes
      rs    = rdata >> {~off, 3'b000};
      h     = off[1] ? rdata[15:0] : rdata[31:16];
      ldata = sz == SZ_B ? {{24{sext & rs[7]}}, rs[7:0]} :
              sz == SZ_H ? {{16{sext & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: MEM-stage req/ack data-bus controller with stall, extension, misalign and timeout.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mem_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_sdata_i,
   input  logic        flush_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stallreq_o,
   output logic        done_o,
   output logic [31:0] ldata_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic        buserr_o
);
   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
   state_t      state, state_n;
   logic [3:0]  op_q;
   logic [1:0]  off_q;
   logic [7:0]  cnt;
   logic        cancel, cancel_n, idle, start, timeout, fin;
   logic        valid, we, mis;
   logic [3:0]  sel;
   logic [31:0] wdata, ext;
   assign idle = state == IDLE;
   // outside IDLE the aligner decodes the latched op so ack capture ignores changed inputs
   mem_align u_align (
      .op    (idle ? mem_op_i : op_q),
      .off   (idle ? mem_addr_i[1:0] : off_q),
      .sdata (mem_sdata_i),
      .rdata (bus_rdata_i),
      .valid (valid),
      .we    (we),
      .mis   (mis),
      .sel   (sel),
      .wdata (wdata),
      .ldata (ext)
   );
   always_comb begin
      start      = idle && valid && !mis && !flush_i;
      cancel_n   = cancel || flush_i;
      timeout    = !bus_ack_i && cnt == 8'(MAX_WAIT - 1);
      fin        = state == BUS && (bus_ack_i || timeout);
      state_n    = idle ? (start ? BUS : IDLE) :
                   state == BUS ? (fin ? (cancel_n ? IDLE : DONE) : BUS) : IDLE;
      stallreq_o = start || state == BUS;
      done_o     = state == DONE && !flush_i;
      adel_o     = idle && mis && !we;
      ades_o     = idle && mis && we;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= '0;
         bus_wdata_o <= '0;
         ldata_o     <= '0;
         buserr_o    <= 1'b0;
         cancel      <= 1'b0;
         cnt         <= '0;
         op_q        <= '0;
         off_q       <= '0;
      end else begin
         state    <= state_n;
         buserr_o <= 1'b0;
         if (idle) begin
            cnt    <= '0;
            cancel <= 1'b0;
         end
         if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= we;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_o   <= sel;
            bus_wdata_o <= wdata;
            op_q        <= mem_op_i;
            off_q       <= mem_addr_i[1:0];
         end
         if (state == BUS) begin
            cnt    <= cnt + 8'd1;
            cancel <= cancel_n;
         end
         if (fin) bus_req_o <= 1'b0;
         if (fin && !cancel_n) begin
            ldata_o  <= bus_ack_i ? ext : '0;
            buserr_o <= timeout;
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized transaction-level reference model checked against the DUT every cycle.
module tb_mem_bus_ctrl;
   localparam int MW = 4;
   logic        clk = 1'b0, rst = 1'b1;
   logic [3:0]  mem_op_i = '0;
   logic [31:0] mem_addr_i = '0, mem_sdata_i = '0, bus_rdata_i = '0;
   logic        flush_i = 1'b0, bus_ack_i = 1'b0;
   logic        bus_req_o, bus_we_o, stallreq_o, done_o, adel_o, ades_o, buserr_o;
   logic [31:0] bus_addr_o, bus_wdata_o, ldata_o;
   logic [3:0]  bus_sel_o;
   logic        chk_en = 1'b0, pin_on = 1'b0;
   logic        e_stall = 0, e_req = 0, e_we = 0, e_done = 0, e_adel = 0, e_ades = 0, e_buserr = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_ldata = 0, r_wdata = 0, r_ldata = 0, m_ldata = 0;
   logic [3:0]  e_sel = 0, r_sel = 0;
   int          n_chk = 0, n_fail = 0;

   mem_bus_ctrl #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
      .mem_sdata_i(mem_sdata_i), .flush_i(flush_i), .bus_req_o(bus_req_o),
      .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
      .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .stallreq_o(stallreq_o), .done_o(done_o), .ldata_o(ldata_o),
      .adel_o(adel_o), .ades_o(ades_o), .buserr_o(buserr_o)
   );

   always #5 clk = ~clk;

   function automatic int nbytes(input logic [3:0] op);
      return (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
   endfunction
   function automatic bit is_valid(input logic [3:0] op);
      return op >= 1 && op <= 8;
   endfunction
   function automatic bit is_store(input logic [3:0] op);
      return op >= 6 && op <= 8;
   endfunction
   function automatic bit is_mis(input logic [3:0] op, input logic [31:0] a);
      return is_valid(op) && (int'(a[1:0]) % nbytes(op)) != 0;
   endfunction
   function automatic logic [3:0] ref_sel(input logic [3:0] op, input logic [31:0] a);
      logic [3:0] s = '0;
      for (int i = 0; i < nbytes(op); i++) s[3 - int'(a[1:0]) - i] = 1'b1;
      return s;
   endfunction
   function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
      logic [31:0] w = '0;
      int n = nbytes(op);
      for (int i = 0; i < 4; i++) w[31 - 8*i -: 8] = d[8*(n - 1 - i % n) +: 8];
      return w;
   endfunction
   function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r);
      longint v = 0;
      int n = nbytes(op);
      int off = int'(a[1:0]);
      for (int i = 0; i < n; i++) v = v * 256 + longint'(r[31 - 8*(off + i) -: 8]);
      if ((op == 1 || op == 3) && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
      return 32'(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (chk_en) begin
      check("stallreq_o", stallreq_o, e_stall);
      check("bus_req_o", bus_req_o, e_req);
      check("done_o", done_o, e_done);
      check("ldata_o", ldata_o, e_ldata);
      check("adel_o", adel_o, e_adel);
      check("ades_o", ades_o, e_ades);
      check("buserr_o", buserr_o, e_buserr);
      if (e_req) begin
         check("bus_we_o", bus_we_o, e_we);
         check("bus_addr_o", bus_addr_o, e_addr);
         check("bus_sel_o", bus_sel_o, e_sel);
         check("bus_wdata_o", bus_wdata_o, e_wdata);
      end
      if (pin_on) begin
         check("model_sel", r_sel, e_sel);
         check("model_wdata", r_wdata, e_wdata);
         if (e_done) check("model_ldata", r_ldata, e_ldata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k: BUS cycle carrying ack (k > MW means never); fj: BUS cycle with flush (0 = none)
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int k, input int fj, input bit fidle,
                         input bit fdone, input bit pin, input logic [3:0] p_sel,
                         input logic [31:0] p_wdata, input logic [31:0] p_ldata);
      bit go, tmo;
      int n_end;
      mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata; bus_rdata_i = rdata;
      flush_i = fidle; bus_ack_i = 1'($urandom_range(0, 1));
      go = is_valid(op) && !is_mis(op, addr) && !fidle;
      e_stall = go; e_req = 0; e_done = 0; e_buserr = 0; e_ldata = m_ldata;
      e_adel = is_mis(op, addr) && !is_store(op);
      e_ades = is_mis(op, addr) && is_store(op);
      tick();
      if (!go) return;
      tmo = k > MW;
      n_end = tmo ? MW : k;
      r_sel = ref_sel(op, addr); r_wdata = ref_wdata(op, sdata);
      e_adel = 0; e_ades = 0; e_req = 1; e_we = is_store(op); e_addr = addr & ~32'd3;
      e_sel = pin ? p_sel : r_sel; e_wdata = pin ? p_wdata : r_wdata; pin_on = pin;
      for (int c = 1; c <= n_end; c++) begin
         flush_i = c == fj;
         bus_ack_i = c == k;
         tick();
      end
      e_req = 0; flush_i = 0; bus_ack_i = 1'($urandom_range(0, 1));
      if (fj != 0) begin
         pin_on = 0;
         return;
      end
      r_ldata = tmo ? 32'd0 : ref_load(op, addr, rdata);
      m_ldata = r_ldata;
      e_stall = 0; e_done = !fdone; flush_i = fdone; e_buserr = tmo;
      e_ldata = pin ? p_ldata : r_ldata;
      tick();
      e_done = 0; e_buserr = 0; flush_i = 0; pin_on = 0;
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] addr;
      int k, ne, fj;
      tick();
      chk_en = 1;
      tick();
      rst = 0;
      tick();
      run_op(4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 0, 0, 1, 4'b1111, 32'h0, 32'hDEADBEEF);
      run_op(4'd1, 32'h103, 32'h0, 32'h123456F0, 1, 0, 0, 0, 1, 4'b0001, 32'h0, 32'hFFFFFFF0);
      run_op(4'd2, 32'h103, 32'h0, 32'h123456F0, 1, 0, 0, 0, 1, 4'b0001, 32'h0, 32'h000000F0);
      run_op(4'd7, 32'h202, 32'h0000ABCD, 32'h0, 1, 0, 0, 0, 1, 4'b0011, 32'hABCDABCD, 32'h0);
      run_op(4'd5, 32'h101, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
      run_op(4'd7, 32'h203, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
      run_op(4'd5, 32'h300, 32'h0, 32'h55AA55AA, MW + 1, 0, 0, 0, 1, 4'b1111, 32'h0, 32'h0);
      run_op(4'd3, 32'h302, 32'h0, 32'h1234F00D, MW, 0, 0, 0, 1, 4'b0011, 32'h0, 32'hFFFFF00D);
      run_op(4'd5, 32'h104, 32'h0, 32'h11111111, 3, 2, 0, 0, 0, 0, 0, 0);
      run_op(4'd5, 32'h108, 32'h0, 32'h22222222, 1, 0, 0, 0, 0, 0, 0, 0);
      run_op(4'd5, 32'h10C, 32'h0, 32'h0, 1, 0, 1, 0, 0, 0, 0, 0);
      run_op(4'd4, 32'h10E, 32'h0, 32'h00008001, 2, 0, 0, 1, 1, 4'b0011, 32'h0, 32'h00008001);
      repeat (400) begin
         op = 4'($urandom_range(0, 10));
         addr = $urandom;
         if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
         k = $urandom_range(1, MW + 1);
         ne = k > MW ? MW : k;
         fj = $urandom_range(0, 5) == 0 ? $urandom_range(1, ne) : 0;
         run_op(op, addr, $urandom, $urandom, k, fj, $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0, 0, 0, 0, 0);
      end
      mem_op_i = 4'd5; mem_addr_i = 32'h400; flush_i = 0; bus_ack_i = 0;
      e_stall = 1; e_req = 0; e_ldata = m_ldata; e_adel = 0; e_ades = 0;
      tick();
      e_req = 1; e_we = 0; e_addr = 32'h400; e_sel = 4'b1111; e_wdata = mem_sdata_i;
      tick();
      rst = 1;
      tick();
      rst = 0; mem_op_i = 4'd0; m_ldata = 0;
      e_stall = 0; e_req = 0; e_ldata = 0;
      tick();
      tick();
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
